cell_loader: RTL and testbench
==============================

CELL_LOADER -- requirements
Module: cell_loader

Interface
REQ-001 Parameter DIMX, default 64, cells per row.
REQ-002 Parameter DIMY, default 64, rows in array.
REQ-003 Parameter PORT_WIDTH, default 32, input word width in bits.
REQ-004 Parameter SLOTS, default DIMX*4/PORT_WIDTH, words per row.
REQ-005 clk  input  1  single FPGA clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin full-array load; sampled only in IDLE.
REQ-008 s_data  input  PORT_WIDTH  config word from Linux (4 bits per cell).
REQ-009 s_valid  input  1  s_data valid.
REQ-010 s_ready  output  1  loader accepts s_data this cycle.
REQ-011 write_en  output  DIMY*SLOTS  one-hot slot write enable; bit index = row*SLOTS + slot.
REQ-012 ram  output  DIMX*4  shared cell config bus to all rows.
REQ-013 busy  output  1  high in any state except IDLE.
REQ-014 done  output  1  one-cycle pulse when last slot of last row is written.

Function
REQ-015 FSM states IDLE, LOAD, WRITE, DONE shall be implemented.
REQ-016 IDLE: start=1 -> LOAD, row and slot counters cleared to 0; start=0 -> stay.
REQ-017 LOAD: s_ready=1; s_valid=1 -> latch s_data into ram[slot*PORT_WIDTH +: PORT_WIDTH], go WRITE; s_valid=0 -> stay.
REQ-018 WRITE: write_en[row*SLOTS+slot]=1 for exactly one cycle, s_ready=0, ram unchanged.
REQ-019 After WRITE: slot<SLOTS-1 -> slot+1, LOAD; slot=SLOTS-1 and row<DIMY-1 -> slot=0, row+1, LOAD; both last -> DONE.
REQ-020 DONE: done=1 for one cycle, then IDLE.
REQ-021 Latency: word accepted at edge N drives write_en high during cycle N+1; throughput one word per two cycles.
REQ-022 ram slices not targeted by current word shall hold their previous value.
REQ-023 write_en shall be all-zero in every state except WRITE; never more than one bit set.
REQ-024 start asserted while busy shall be ignored.
REQ-025 s_ready shall be 0 in IDLE, WRITE, DONE.
REQ-026 Row/slot counters sized $clog2 of DIMY/SLOTS (minimum 1 bit); no wrap beyond DIMY-1/SLOTS-1.

Reset
REQ-027 reset=1 at any edge, including mid-load: state IDLE, counters 0, ram 0, write_en 0, s_ready 0, busy 0, done 0.
REQ-028 reset shall take priority over start and s_valid in the same cycle.

Configuration
REQ-029 Macro CELL_LOADER_CHECKSUM_EN defined: extra output checksum [PORT_WIDTH-1:0], XOR of all words accepted since last start, cleared on start and reset, valid when done pulses.
REQ-030 Macro undefined: no checksum port or logic; all other behaviour identical.

Structure
REQ-031 Shared package cell_pkg shall hold the FSM state enum and default DIMX/DIMY/PORT_WIDTH constants.
REQ-032 Single module, no sub-modules; parameter check DIMX*4 % PORT_WIDTH == 0 at elaboration.

Verification (DIMX=16, DIMY=2, PORT_WIDTH=32, SLOTS=2)
REQ-033 Full load: start, words 0x11111111,0x22222222,0x33333333,0x44444444 with s_valid held -> write_en 0001,0010,0100,1000 each one cycle after accept; ram=0x2222222211111111 at second pulse; done one cycle after fourth pulse.
REQ-034 Backpressure gaps: s_valid low 3 cycles between words -> state holds LOAD, write_en 0, same pulse sequence.
REQ-035 Reset mid-load: reset after second write -> all outputs 0 next cycle; new start restarts at write_en=0001.
REQ-036 start pulsed during LOAD -> ignored, counters unchanged, done only after fourth word.
REQ-037 CELL_LOADER_CHECKSUM_EN: above four words -> checksum 0x44444444 at done.

Source files
------------

// File: rtl/cell_loader_pkg.sv
// Shared types and default geometry for the cell configuration loader.
package cell_pkg;

  localparam int unsigned DEF_DIMX       = 64;
  localparam int unsigned DEF_DIMY       = 64;
  localparam int unsigned DEF_PORT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Counter width that never collapses to zero bits for a single row/slot.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cell_loader_if.sv
// Valid/ready word stream feeding the cell loader.
interface cell_loader_if
  import cell_pkg::*;
#(
  parameter int unsigned PORT_WIDTH = DEF_PORT_WIDTH
);

  logic [PORT_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);

endinterface

// File: rtl/cell_loader.sv
// Streams config words into a shared row bus and pulses one row/slot write enable per word.
// Optional build macro CELL_LOADER_CHECKSUM_EN adds an XOR checksum output of the accepted words.
module cell_loader
  import cell_pkg::*;
#(
  parameter int unsigned DIMX       = DEF_DIMX,
  parameter int unsigned DIMY       = DEF_DIMY,
  parameter int unsigned PORT_WIDTH = DEF_PORT_WIDTH,
  parameter int unsigned SLOTS      = DIMX * 4 / PORT_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  cell_loader_if.slave              s_if,
  output logic [DIMY*SLOTS-1:0]     write_en,
  output logic [DIMX*4-1:0]         ram,
  output logic                      busy,
  output logic                      done
`ifdef CELL_LOADER_CHECKSUM_EN
  ,
  output logic [PORT_WIDTH-1:0]     checksum
`endif
);

  localparam int unsigned RAM_W  = DIMX * 4;
  localparam int unsigned WE_W   = DIMY * SLOTS;
  localparam int unsigned ROW_W  = clog2_min1(DIMY);
  localparam int unsigned SLOT_W = clog2_min1(SLOTS);
  localparam logic [PORT_WIDTH-1:0] SLICE_ONES = {PORT_WIDTH{1'b1}};

  if ((RAM_W % PORT_WIDTH) != 0 || (SLOTS * PORT_WIDTH) != RAM_W) begin : g_bad_geometry
    $error("cell_loader: DIMX*4 must be a multiple of PORT_WIDTH and equal SLOTS*PORT_WIDTH");
  end

  state_e              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;

  logic [RAM_W-1:0]    ram_q, ram_d;
  logic [WE_W-1:0]     write_en_q, write_en_d;
  logic                s_ready_q, s_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef CELL_LOADER_CHECKSUM_EN
  logic [PORT_WIDTH-1:0] csum_q, csum_d;
`endif

  logic                accept_c;
  logic [31:0]         slot_shift_c;
  logic [31:0]         we_idx_c;

  assign accept_c     = (state_q == ST_LOAD) && s_if.s_valid;
  assign slot_shift_c = 32'(slot_q) * PORT_WIDTH;
  assign we_idx_c     = 32'(row_q) * SLOTS + 32'(slot_q);

  // State and row/slot counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      slot_q  <= slot_d;
    end
  end

  // Next state; counters stop at the last row/slot instead of wrapping.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    slot_d  = slot_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          row_d   = '0;
          slot_d  = '0;
        end
      end
      ST_LOAD: begin
        if (s_if.s_valid) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (slot_q != SLOT_W'(SLOTS - 1)) begin
          slot_d  = slot_q + SLOT_W'(1);
          state_d = ST_LOAD;
        end else if (row_q != ROW_W'(DIMY - 1)) begin
          slot_d  = '0;
          row_d   = row_q + ROW_W'(1);
          state_d = ST_LOAD;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values; flags are decoded from the upcoming state so they align with it.
  always_comb begin
    ram_d      = ram_q;
    write_en_d = '0;
    s_ready_d  = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
`ifdef CELL_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
    if (state_q == ST_IDLE && start) csum_d = '0;
`endif
    if (accept_c) begin
      ram_d      = (ram_q & ~(RAM_W'(SLICE_ONES) << slot_shift_c))
                 | (RAM_W'(s_if.s_data) << slot_shift_c);
      write_en_d = WE_W'(1) << we_idx_c;
`ifdef CELL_LOADER_CHECKSUM_EN
      csum_d     = csum_q ^ s_if.s_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_q      <= '0;
      write_en_q <= '0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef CELL_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      ram_q      <= ram_d;
      write_en_q <= write_en_d;
      s_ready_q  <= s_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef CELL_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign s_if.s_ready = s_ready_q;
  assign write_en     = write_en_q;
  assign ram          = ram_q;
  assign busy         = busy_q;
  assign done         = done_q;
`ifdef CELL_LOADER_CHECKSUM_EN
  assign checksum     = csum_q;
`endif

endmodule

// File: tb/tb_cell_loader.sv
// Randomized self-checking bench for cell_loader against a word-indexed transaction model.
module tb_cell_loader;
  import cell_pkg::*;

  localparam int unsigned DIMX   = 16;
  localparam int unsigned DIMY   = 2;
  localparam int unsigned PW     = 32;
  localparam int unsigned SLOTS  = DIMX * 4 / PW;
  localparam int unsigned RAM_W  = DIMX * 4;
  localparam int unsigned WE_W   = DIMY * SLOTS;
  localparam int unsigned NWORDS = DIMY * SLOTS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             start;
  logic [WE_W-1:0]  write_en;
  logic [RAM_W-1:0] ram;
  logic             busy;
  logic             done;
`ifdef CELL_LOADER_CHECKSUM_EN
  logic [PW-1:0]    checksum;
`endif

  cell_loader_if #(.PORT_WIDTH(PW)) s_if ();

  cell_loader #(.DIMX(DIMX), .DIMY(DIMY), .PORT_WIDTH(PW), .SLOTS(SLOTS)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .s_if     (s_if),
    .write_en (write_en),
    .ram      (ram),
    .busy     (busy),
    .done     (done)
`ifdef CELL_LOADER_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  int checks;
  int errors;
  logic [RAM_W-1:0] ram_m;
  logic [PW-1:0]    csum_m;

  // Full array load: word k lands in row k/SLOTS, slot k%SLOTS, and pulses bit row*SLOTS+slot.
  task automatic run_load(input logic [PW-1:0] w [NWORDS], input int gap [NWORDS],
                          input bit noise, input string tag);
    logic [WE_W+2:0] got, exp;
    int row, slot;
    start = 1'b1;
    s_if.s_valid = 1'b0;
    @(negedge clk);
    start  = 1'b0;
    csum_m = '0;
    got = {busy, s_if.s_ready, done, write_en};
    exp = {1'b1, 1'b1, 1'b0, WE_W'(0)};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s_enter: got %b want %b", tag, got, exp); end
    for (int k = 0; k < NWORDS; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = $urandom;
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        got = {busy, s_if.s_ready, done, write_en};
        exp = {1'b1, 1'b1, 1'b0, WE_W'(0)};
        checks++;
        if (got !== exp) begin errors++; $display("FAIL %s_gap w%0d: got %b want %b", tag, k, got, exp); end
      end
      s_if.s_valid = 1'b1;
      s_if.s_data  = w[k];
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      row  = k / SLOTS;
      slot = k % SLOTS;
      ram_m[slot*PW +: PW] = w[k];
      csum_m ^= w[k];
      got = {busy, s_if.s_ready, done, write_en};
      exp = {1'b1, 1'b0, 1'b0, WE_W'(WE_W'(1) << (row * SLOTS + slot))};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s_write w%0d: got %b want %b", tag, k, got, exp); end
      checks++;
      if (ram !== ram_m) begin errors++; $display("FAIL %s_ram w%0d: got %h want %h", tag, k, ram, ram_m); end
      // Holding valid through the write cycle must not be taken as a second word.
      if (k < NWORDS - 1 && gap[k+1] == 0) begin
        s_if.s_valid = 1'b1;
        s_if.s_data  = w[k+1];
      end else begin
        s_if.s_valid = 1'b0;
        s_if.s_data  = $urandom;
      end
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      got = {busy, s_if.s_ready, done, write_en};
      exp = (k < NWORDS - 1) ? {1'b1, 1'b1, 1'b0, WE_W'(0)} : {1'b1, 1'b0, 1'b1, WE_W'(0)};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL %s_after w%0d: got %b want %b", tag, k, got, exp); end
    end
`ifdef CELL_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== csum_m) begin errors++; $display("FAIL %s_checksum: got %h want %h", tag, checksum, csum_m); end
`endif
    s_if.s_valid = 1'b0;
    start = 1'b0;
    @(negedge clk);
    got = {busy, s_if.s_ready, done, write_en};
    exp = '0;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL %s_exit: got %b want %b", tag, got, exp); end
    checks++;
    if (ram !== ram_m) begin errors++; $display("FAIL %s_ram_hold: got %h want %h", tag, ram, ram_m); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b1;
    s_if.s_valid = 1'b1;
    s_if.s_data  = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, s_if.s_ready, done, write_en} !== '0) begin
      errors++; $display("FAIL reset_flags: got %b want 0", {busy, s_if.s_ready, done, write_en});
    end
    checks++;
    if (ram !== '0) begin errors++; $display("FAIL reset_ram: got %h want 0", ram); end
    reset = 1'b0;
    start = 1'b0;
    s_if.s_valid = 1'b0;
    ram_m = '0;
  endtask

  task automatic test_idle_ignores_data();
    for (int i = 0; i < 3; i++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = $urandom;
      @(negedge clk);
      checks++;
      if ({busy, s_if.s_ready, done, write_en} !== '0 || ram !== ram_m) begin
        errors++; $display("FAIL idle_hold: flags %b ram %h want 0 / %h",
                           {busy, s_if.s_ready, done, write_en}, ram, ram_m);
      end
    end
    s_if.s_valid = 1'b0;
  endtask

  task automatic test_full_load();
    logic [PW-1:0] w [NWORDS];
    int gap [NWORDS];
    w   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    gap = '{default: 0};
    run_load(w, gap, 1'b0, "full");
    checks++;
    if (ram !== 64'h4444444433333333) begin errors++; $display("FAIL full_final_ram: got %h want 4444444433333333", ram); end
`ifdef CELL_LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== 32'h44444444) begin errors++; $display("FAIL full_checksum_const: got %h want 44444444", checksum); end
`endif
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] w [NWORDS];
    int gap [NWORDS];
    w   = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    gap = '{default: 3};
    run_load(w, gap, 1'b0, "gaps");
  endtask

  task automatic test_reset_mid_load();
    logic [PW-1:0] w [NWORDS];
    int gap [NWORDS];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_if.s_valid = 1'b1;
      s_if.s_data  = $urandom;
      @(negedge clk);
      checks++;
      if (write_en !== WE_W'(WE_W'(1) << k)) begin
        errors++; $display("FAIL midrst_pulse w%0d: got %b want %b", k, write_en, WE_W'(WE_W'(1) << k));
      end
      s_if.s_valid = 1'b0;
      @(negedge clk);
    end
    reset = 1'b1;
    start = 1'b1;
    s_if.s_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, s_if.s_ready, done, write_en} !== '0 || ram !== '0) begin
      errors++; $display("FAIL midrst_clear: flags %b ram %h want all 0", {busy, s_if.s_ready, done, write_en}, ram);
    end
    reset = 1'b0;
    start = 1'b0;
    s_if.s_valid = 1'b0;
    ram_m = '0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_idle: busy %b want 0", busy); end
    w   = '{32'hA5A5A5A5, 32'h0F0F0F0F, 32'h12345678, 32'h9ABCDEF0};
    gap = '{default: 0};
    run_load(w, gap, 1'b0, "restart");
  endtask

  task automatic test_start_ignored();
    logic [PW-1:0] w [NWORDS];
    int gap [NWORDS];
    foreach (w[j]) w[j] = $urandom;
    gap = '{1, 2, 0, 1};
    run_load(w, gap, 1'b1, "startnoise");
  endtask

  task automatic test_random();
    logic [PW-1:0] w [NWORDS];
    int gap [NWORDS];
    for (int i = 0; i < 6; i++) begin
      foreach (w[j]) begin
        w[j]   = $urandom;
        gap[j] = $urandom_range(0, 3);
      end
      run_load(w, gap, 1'($urandom_range(0, 1)), "rand");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    start  = 1'b0;
    s_if.s_valid = 1'b0;
    s_if.s_data  = '0;
    ram_m  = '0;
    csum_m = '0;
    test_reset();
    test_idle_ignores_data();
    test_full_load();
    test_backpressure();
    test_reset_mid_load();
    test_start_ignored();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
